dma_priority_arbiter: RTL and testbench
=======================================

# dma_priority_arbiter

Channel priority and bus-request sequencer for the four-channel DMA controller. Samples DREQ against the mask and selects one channel under fixed or rotating priority. Runs the HRQ/HLDA handshake with the CPU and drives DACK for the granted channel until the timing-and-control block reports end of service. Sits between the bus interface and the timing-and-control state machine; the register file supplies its priority order and mask.

## Interface
Parameters:
- NUM_CH, 4, number of DMA channels; the design is fixed at 4.
- CH_W, 2, width of a channel index.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- DREQ  in  4  per-channel DMA request.
- dreqSenseLow  in  1  command-register bit: 1 means DREQ is active-low.
- priorityType  in  1  command-register bit: 0 selects fixed priority, 1 selects rotating priority.
- maskReg  in  4  per-channel mask; 1 blocks the channel.
- HLDA  in  1  CPU hold acknowledge.
- serviceDone  in  1  one-cycle pulse from timing-and-control when the granted transfer completes (S4 exit or EOP).
- HRQ  out  1  hold request to the CPU.
- DACK  out  4  one-hot acknowledge, active-high.
- grantValid  out  1  a channel is currently granted.
- grantCh  out  2  index of the granted channel.
- priorityOrder  out  8  four 2-bit fields; [1:0] holds the highest-priority channel.

## Operation
- Effective request is reqEff = (DREQ ^ {4{dreqSenseLow}}) & ~maskReg, registered once into reqQ.
- The winner is the first channel in priorityOrder, scanned from [1:0] to [7:6], whose reqQ bit is set.
- Three states:
  - IDLE: HRQ=0, DACK=0. Moves to REQ when |reqQ.
  - REQ: HRQ=1.
    - If reqQ==0, return to IDLE and drop HRQ. A withdrawn request is allowed.
    - Else, on HLDA=1, latch the winner into grantCh and move to GRANT.
  - GRANT: HRQ=1, grantValid=1, DACK=onehot(grantCh).
    - On serviceDone, move to IDLE.
    - If priorityType=1, also rotate: the serviced channel becomes lowest and the other three keep their relative order shifted up.
    - If HLDA drops while in GRANT, abort to IDLE with no rotation.
- Changes to mask or DREQ during GRANT never preempt the current grant; they are used only at the next REQ decision.
- When priorityType=0, priorityOrder is forced to 8'b11_10_01_00 every cycle.
- If serviceDone and an HLDA drop occur in the same cycle, serviceDone wins and rotation applies.
- serviceDone is ignored outside GRANT.

## Timing
- Reset values: HRQ=0, DACK=4'b0000, grantValid=0, grantCh=0, priorityOrder=8'b11_10_01_00, reqQ=0, state=IDLE.
- Reset is asynchronous: asserting RESET_N low clears all state immediately, including mid-grant.
- All outputs are registered.
- DREQ to HRQ is 2 cycles: the reqQ sample, then the IDLE→REQ edge.
- HLDA sampled high in REQ → DACK and grantValid assert on the next edge.
- serviceDone sampled → DACK, HRQ and grantValid drop on the next edge, and priorityOrder updates on that same edge.
- Back-to-back service: at least one IDLE cycle between grants, so HRQ is low for at least 1 cycle.

## Structure
- dma_pkg holds:
  - the state enum (IDLE, REQ, GRANT);
  - the type chan_t (logic [1:0]);
  - the constant DEFAULT_PRIORITY = 8'b11_10_01_00.
- Sub-module dma_priority_resolver is purely combinational: (reqQ, priorityOrder) → (winnerValid, winnerCh).
- The top level holds the FSM, the reqQ register and the rotation logic.

## Test plan
- Fixed priority, DREQ=4'b1110 with HLDA held high → HRQ asserts 2 cycles after DREQ; DACK=4'b0010 one cycle after HLDA is seen in REQ; grantCh=1.
- Rotating priority, DREQ=4'b1111, four serviceDone pulses → DACK sequence 0001, 0010, 0100, 1000; priorityOrder after the first grant is 8'b00_11_10_01.
- maskReg=4'b0001 with DREQ=4'b0001 → HRQ stays 0; unmasking → HRQ=1 two cycles later.
- dreqSenseLow=1, DREQ=4'b1011 → effective request is ch2; DACK=4'b0100.
- HLDA dropped mid-GRANT with rotating priority → back to IDLE next edge; DACK=0; priorityOrder unchanged.
- RESET_N pulsed low during GRANT → outputs and priorityOrder return to their reset values asynchronously, before the next clock edge.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA channel priority arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dma_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    GRANT = 2'd2
  } state_e;

  typedef logic [1:0] chan_t;

  // Field [1:0] is the highest-priority channel.
  localparam logic [7:0] DEFAULT_PRIORITY = 8'b11_10_01_00;

  // Move the serviced channel to the lowest slot. The other three channels
  // shift up toward [1:0] and keep their relative order.
  function automatic logic [7:0] rotate_order(input logic [7:0] order, input chan_t ch);
    logic [7:0] res;
    int         k;
    res = '0;
    k   = 0;
    for (int i = 0; i < 4; i++) begin
      if (order[2*i +: 2] != ch && k < 3) begin
        res[2*k +: 2] = order[2*i +: 2];
        k = k + 1;
      end
    end
    res[7:6] = ch;
    return res;
  endfunction

endpackage

// File: rtl/dma_priority_resolver.sv
// Picks the first requesting channel in priority order, scanning from [1:0] upward.
// Latency: purely combinational.
// Backpressure: none; the result is consumed only when the FSM decides a grant.
module dma_priority_resolver
  import dma_pkg::*;
(
  input  logic [3:0] req_q,
  input  logic [7:0] priority_order,
  output logic       winner_valid,
  output chan_t      winner_ch
);

  // Priority scan: the lowest slot with a pending request wins.
  always_comb begin
    winner_valid = 1'b0;
    winner_ch    = '0;
    for (int i = 0; i < 4; i++) begin
      if (!winner_valid && req_q[priority_order[2*i +: 2]]) begin
        winner_valid = 1'b1;
        winner_ch    = priority_order[2*i +: 2];
      end
    end
  end

endmodule

// File: rtl/dma_priority_arbiter.sv
// DMA channel arbiter: samples masked DREQ, runs the HRQ/HLDA handshake, and holds DACK until service ends.
// Latency: DREQ->HRQ 2 cycles; HLDA in REQ->DACK 1 cycle; serviceDone->release 1 cycle; all outputs registered.
// Backpressure: the grant is held while HLDA stays high; request or mask changes never preempt it.
module dma_priority_arbiter
  import dma_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic [NUM_CH-1:0]   DREQ,
  input  logic                dreqSenseLow,
  input  logic                priorityType,
  input  logic [NUM_CH-1:0]   maskReg,
  input  logic                HLDA,
  input  logic                serviceDone,
  output logic                HRQ,
  output logic [NUM_CH-1:0]   DACK,
  output logic                grantValid,
  output logic [CH_W-1:0]     grantCh,
  output logic [2*NUM_CH-1:0] priorityOrder
);

  state_e              state_q, state_d;
  logic [NUM_CH-1:0]   req_q, req_d;
  logic                hrq_q, hrq_d;
  logic [NUM_CH-1:0]   dack_q, dack_d;
  logic                grant_valid_q, grant_valid_d;
  logic [CH_W-1:0]     grant_ch_q, grant_ch_d;
  logic [2*NUM_CH-1:0] order_q, order_d;

  logic                winner_valid;
  chan_t               winner_ch;

  dma_priority_resolver u_resolver (
    .req_q          (req_q),
    .priority_order (order_q),
    .winner_valid   (winner_valid),
    .winner_ch      (winner_ch)
  );

  // Next-state, rotation and registered-output values; outputs follow the next state.
  always_comb begin
    state_d    = state_q;
    grant_ch_d = grant_ch_q;
    order_d    = priorityType ? order_q : DEFAULT_PRIORITY;
    req_d      = (DREQ ^ {NUM_CH{dreqSenseLow}}) & ~maskReg;

    case (state_q)
      IDLE: begin
        if (|req_q) state_d = REQ;
      end
      REQ: begin
        // A request withdrawn before HLDA simply drops the hold request.
        if (req_q == '0) begin
          state_d = IDLE;
        end else if (HLDA && winner_valid) begin
          grant_ch_d = winner_ch;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        // Completion takes precedence over a simultaneous HLDA drop.
        if (serviceDone) begin
          state_d = IDLE;
          if (priorityType) order_d = rotate_order(order_q, grant_ch_q);
        end else if (!HLDA) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    hrq_d         = (state_d != IDLE);
    grant_valid_d = (state_d == GRANT);
    dack_d        = grant_valid_d ? ({{(NUM_CH-1){1'b0}}, 1'b1} << grant_ch_d) : '0;
  end

  // State, request sample and output registers; reset clears everything immediately.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q       <= IDLE;
      req_q         <= '0;
      hrq_q         <= 1'b0;
      dack_q        <= '0;
      grant_valid_q <= 1'b0;
      grant_ch_q    <= '0;
      order_q       <= DEFAULT_PRIORITY;
    end else begin
      state_q       <= state_d;
      req_q         <= req_d;
      hrq_q         <= hrq_d;
      dack_q        <= dack_d;
      grant_valid_q <= grant_valid_d;
      grant_ch_q    <= grant_ch_d;
      order_q       <= order_d;
    end
  end

  assign HRQ           = hrq_q;
  assign DACK          = dack_q;
  assign grantValid    = grant_valid_q;
  assign grantCh       = grant_ch_q;
  assign priorityOrder = order_q;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Directed bench for dma_priority_arbiter: a per-cycle vector table plus hand-written corner sequences.
// Latency: inputs are applied 1 time unit after a rising edge, and outputs are checked 1 time unit after the next rising edge.
// Backpressure: n/a.
module tb_dma_priority_arbiter;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic [3:0] DREQ;
  logic       dreqSenseLow;
  logic       priorityType;
  logic [3:0] maskReg;
  logic       HLDA;
  logic       serviceDone;
  logic       HRQ;
  logic [3:0] DACK;
  logic       grantValid;
  logic [1:0] grantCh;
  logic [7:0] priorityOrder;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  dma_priority_arbiter #(.NUM_CH(4), .CH_W(2)) dut (
    .CLK           (CLK),
    .RESET_N       (RESET_N),
    .DREQ          (DREQ),
    .dreqSenseLow  (dreqSenseLow),
    .priorityType  (priorityType),
    .maskReg       (maskReg),
    .HLDA          (HLDA),
    .serviceDone   (serviceDone),
    .HRQ           (HRQ),
    .DACK          (DACK),
    .grantValid    (grantValid),
    .grantCh       (grantCh),
    .priorityOrder (priorityOrder)
  );

  typedef struct {
    logic [3:0] dreq;
    logic       sense;
    logic       ptype;
    logic [3:0] mask;
    logic       hlda;
    logic       sdone;
    logic       hrq;
    logic [3:0] dack;
    logic       gv;
    logic [1:0] gch;
    logic [7:0] po;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic hrq, input logic [3:0] dack,
                           input logic gv, input logic [1:0] gch, input logic [7:0] po);
    check({tag, ".hrq"},  {7'd0, HRQ},        {7'd0, hrq});
    check({tag, ".dack"}, {4'd0, DACK},       {4'd0, dack});
    check({tag, ".gv"},   {7'd0, grantValid}, {7'd0, gv});
    check({tag, ".gch"},  {6'd0, grantCh},    {6'd0, gch});
    check({tag, ".po"},   priorityOrder,      po);
  endtask

  task automatic add(input logic [3:0] dreq, input logic sense, input logic ptype,
                     input logic [3:0] mask, input logic hlda, input logic sdone,
                     input logic hrq, input logic [3:0] dack, input logic gv,
                     input logic [1:0] gch, input logic [7:0] po);
    vec_t v;
    v.dreq = dreq; v.sense = sense; v.ptype = ptype; v.mask = mask;
    v.hlda = hlda; v.sdone = sdone;
    v.hrq = hrq; v.dack = dack; v.gv = gv; v.gch = gch; v.po = po;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RESET_N = 1'b0; DREQ = '0; dreqSenseLow = 1'b0; priorityType = 1'b0;
    maskReg = '0; HLDA = 1'b0; serviceDone = 1'b0;

    //  dreq   sns pt mask   hl sd | hrq dack   gv gch po
    // Fixed priority, DREQ=1110, HLDA held high.
    add(4'b1110,0,0,4'b0000,1,0,   0,4'b0000,0,2'd0,8'he4);
    add(4'b1110,0,0,4'b0000,1,0,   1,4'b0000,0,2'd0,8'he4);
    add(4'b1110,0,0,4'b0000,1,0,   1,4'b0010,1,2'd1,8'he4);
    add(4'b1110,0,0,4'b0000,1,0,   1,4'b0010,1,2'd1,8'he4);
    add(4'b0000,0,0,4'b0000,1,1,   0,4'b0000,0,2'd1,8'he4);
    add(4'b0000,0,0,4'b0000,0,0,   0,4'b0000,0,2'd1,8'he4);
    // Rotating priority, all four channels requesting.
    add(4'b1111,0,1,4'b0000,1,0,   0,4'b0000,0,2'd1,8'he4);
    add(4'b1111,0,1,4'b0000,1,0,   1,4'b0000,0,2'd1,8'he4);
    add(4'b1111,0,1,4'b0000,1,0,   1,4'b0001,1,2'd0,8'he4);
    add(4'b1111,0,1,4'b0000,1,1,   0,4'b0000,0,2'd0,8'h39);
    add(4'b1111,0,1,4'b0000,1,0,   1,4'b0000,0,2'd0,8'h39);
    add(4'b1111,0,1,4'b0000,1,0,   1,4'b0010,1,2'd1,8'h39);
    add(4'b1111,0,1,4'b0000,1,1,   0,4'b0000,0,2'd1,8'h4e);
    add(4'b1111,0,1,4'b0000,1,0,   1,4'b0000,0,2'd1,8'h4e);
    add(4'b1111,0,1,4'b0000,1,0,   1,4'b0100,1,2'd2,8'h4e);
    add(4'b1111,0,1,4'b0000,1,1,   0,4'b0000,0,2'd2,8'h93);
    add(4'b1111,0,1,4'b0000,1,0,   1,4'b0000,0,2'd2,8'h93);
    add(4'b1111,0,1,4'b0000,1,0,   1,4'b1000,1,2'd3,8'h93);
    add(4'b0000,0,1,4'b0000,1,1,   0,4'b0000,0,2'd3,8'he4);
    add(4'b0000,0,1,4'b0000,0,0,   0,4'b0000,0,2'd3,8'he4);
    // Masked request stays silent; unmasking raises HRQ two cycles later; then withdrawal.
    add(4'b0001,0,0,4'b0001,0,0,   0,4'b0000,0,2'd3,8'he4);
    add(4'b0001,0,0,4'b0001,0,0,   0,4'b0000,0,2'd3,8'he4);
    add(4'b0001,0,0,4'b0001,0,0,   0,4'b0000,0,2'd3,8'he4);
    add(4'b0001,0,0,4'b0000,0,0,   0,4'b0000,0,2'd3,8'he4);
    add(4'b0001,0,0,4'b0000,0,0,   1,4'b0000,0,2'd3,8'he4);
    add(4'b0000,0,0,4'b0000,0,0,   1,4'b0000,0,2'd3,8'he4);
    add(4'b0000,0,0,4'b0000,0,0,   0,4'b0000,0,2'd3,8'he4);
    // Active-low DREQ sense: 1011 means only ch2 is requesting.
    add(4'b1011,1,0,4'b0000,1,0,   0,4'b0000,0,2'd3,8'he4);
    add(4'b1011,1,0,4'b0000,1,0,   1,4'b0000,0,2'd3,8'he4);
    add(4'b1011,1,0,4'b0000,1,0,   1,4'b0100,1,2'd2,8'he4);
    add(4'b1111,1,0,4'b0000,1,1,   0,4'b0000,0,2'd2,8'he4);
    add(4'b1111,1,0,4'b0000,0,1,   0,4'b0000,0,2'd2,8'he4);

    step(); step();
    check_all("reset", 1'b0, 4'b0000, 1'b0, 2'd0, 8'he4);
    RESET_N = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      DREQ = vecs[i].dreq; dreqSenseLow = vecs[i].sense; priorityType = vecs[i].ptype;
      maskReg = vecs[i].mask; HLDA = vecs[i].hlda; serviceDone = vecs[i].sdone;
      step();
      check_all($sformatf("v%0d", i), vecs[i].hrq, vecs[i].dack, vecs[i].gv, vecs[i].gch, vecs[i].po);
    end

    // Grant held against later mask/request changes; HLDA drop aborts without rotation.
    dreqSenseLow = 1'b0; priorityType = 1'b1; maskReg = 4'b0000;
    DREQ = 4'b0100; HLDA = 1'b1; serviceDone = 1'b0;
    step(); step(); step();
    check_all("a_grant", 1'b1, 4'b0100, 1'b1, 2'd2, 8'he4);
    maskReg = 4'b0100; DREQ = 4'b0101;
    step();
    check_all("a_nopreempt", 1'b1, 4'b0100, 1'b1, 2'd2, 8'he4);
    HLDA = 1'b0;
    step();
    check_all("a_abort", 1'b0, 4'b0000, 1'b0, 2'd2, 8'he4);
    maskReg = 4'b0000; DREQ = 4'b0100; HLDA = 1'b1;
    step(); step();
    check_all("a_regrant", 1'b1, 4'b0100, 1'b1, 2'd2, 8'he4);
    // serviceDone and HLDA drop in the same cycle: completion wins, so the order rotates.
    serviceDone = 1'b1; HLDA = 1'b0;
    step();
    check_all("a_done_drop", 1'b0, 4'b0000, 1'b0, 2'd2, 8'hb4);

    // Asynchronous reset in the middle of a grant.
    serviceDone = 1'b0; HLDA = 1'b1;
    step(); step();
    check_all("r_pre", 1'b1, 4'b0100, 1'b1, 2'd2, 8'hb4);
    #3 RESET_N = 1'b0;
    #1;
    check_all("r_async", 1'b0, 4'b0000, 1'b0, 2'd0, 8'he4);
    step();
    RESET_N = 1'b1;

    // Rotation after reset, then fixed mode forces the default order.
    step(); step(); step();
    check_all("f_grant", 1'b1, 4'b0100, 1'b1, 2'd2, 8'he4);
    serviceDone = 1'b1;
    step();
    check("f_rot.po", priorityOrder, 8'hb4);
    serviceDone = 1'b0; DREQ = 4'b0000; priorityType = 1'b0;
    step();
    check("f_force.po", priorityOrder, 8'he4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
